// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Brief    : Shared constants and types for the direct-mapped instruction cache
// Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

  localparam int WORD_W         = 32;
  localparam int DEF_LINES      = 64;
  localparam int DEF_LINE_WORDS = 4;

  // Address split for the default geometry.
  localparam int OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int IDX_W = $clog2(DEF_LINES);
  localparam int TAG_W = WORD_W - 2 - OFF_W - IDX_W;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/icache_ram.sv
`default_nettype none
// ============================================================================
// Module   : icache_ram
// Brief    : Asynchronous-read, synchronous-write storage array (no reset)
// Revision : 1.0 - initial release
// ============================================================================
module icache_ram
  import icache_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = WORD_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Brief    : Direct-mapped read-only instruction cache, line refill on miss
// Revision : 1.0 - initial release
// ============================================================================
module icache
  import icache_pkg::*;
#(
  parameter int LINES      = DEF_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WORD_W-1:0] i_addr,
  input  logic              i_flush,
  output logic [WORD_W-1:0] o_data,
  output logic              o_ready,
  output logic              o_mem_rd,
  output logic [WORD_W-1:0] o_mem_addr,
  input  logic [WORD_W-1:0] i_mem_data,
  input  logic              i_mem_ack
);

  localparam int OFF_B = $clog2(LINE_WORDS);
  localparam int IDX_B = $clog2(LINES);
  localparam int TAG_B = WORD_W - 2 - OFF_B - IDX_B;

  state_t             state;
  logic [OFF_B-1:0]   cnt;
  logic [IDX_B-1:0]   base_idx;
  logic [TAG_B-1:0]   base_tag;
  logic [LINES-1:0]   valid;
  logic               flush_pend;

  logic [OFF_B-1:0]   a_off;
  logic [IDX_B-1:0]   a_idx;
  logic [TAG_B-1:0]   a_tag;
  logic [TAG_B-1:0]   tag_rd;
  logic               hit;
  logic               fill;
  logic               last;
  logic               unused_bits;

  assign a_off       = i_addr[OFF_B+1:2];
  assign a_idx       = i_addr[OFF_B+IDX_B+1:OFF_B+2];
  assign a_tag       = i_addr[WORD_W-1:OFF_B+IDX_B+2];
  assign unused_bits = ^i_addr[1:0];

  assign hit     = (state == IDLE) && valid[a_idx] && (tag_rd == a_tag);
  assign o_ready = hit;
  assign fill    = (state == REFILL) && i_mem_ack;
  assign last    = (cnt == OFF_B'(LINE_WORDS - 1));

  icache_ram #(
    .DEPTH (LINES * LINE_WORDS),
    .WIDTH (WORD_W)
  ) u_data (
    .clk   (i_clk),
    .we    (fill),
    .waddr ({base_idx, cnt}),
    .wdata (i_mem_data),
    .raddr ({a_idx, a_off}),
    .rdata (o_data)
  );

  // Tag is only committed once the whole line has landed.
  icache_ram #(
    .DEPTH (LINES),
    .WIDTH (TAG_B)
  ) u_tag (
    .clk   (i_clk),
    .we    (fill && last),
    .waddr (base_idx),
    .wdata (base_tag),
    .raddr (a_idx),
    .rdata (tag_rd)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      valid      <= '0;
      flush_pend <= 1'b0;
      o_mem_rd   <= 1'b0;
      o_mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_flush) valid <= '0;
          if (!hit) begin
            state      <= REFILL;
            base_idx   <= a_idx;
            base_tag   <= a_tag;
            cnt        <= '0;
            o_mem_rd   <= 1'b1;
            o_mem_addr <= {i_addr[WORD_W-1:OFF_B+2], {(OFF_B+2){1'b0}}};
          end
        end
        REFILL: begin
          if (i_flush) flush_pend <= 1'b1;
          if (i_mem_ack) begin
            cnt        <= cnt + 1'b1;
            o_mem_addr <= o_mem_addr + 32'd4;
            if (last) begin
              // A flush seen at any point of the refill wins over the new line.
              state      <= IDLE;
              o_mem_rd   <= 1'b0;
              flush_pend <= 1'b0;
              if (flush_pend || i_flush) valid <= '0;
              else                       valid[base_idx] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
